// File: rtl/i2s_rx_stream_arbiter_if.sv
// i2s_rx_stream_arbiter_if: channel sample inputs and uDMA output stream of the arbiter.
interface i2s_rx_stream_arbiter_if;
    logic [31:0] ch0_data_i;
    logic [31:0] ch1_data_i;
    logic        ch0_valid_i;
    logic        ch1_valid_i;
    logic        ch0_ready_o;
    logic        ch1_ready_o;
    logic [31:0] udma_data_o;
    logic        udma_chid_o;
    logic        udma_valid_o;
    logic        udma_ready_i;
    modport master (
        input  ch0_data_i, ch1_data_i, ch0_valid_i, ch1_valid_i, udma_ready_i,
        output ch0_ready_o, ch1_ready_o, udma_data_o, udma_chid_o, udma_valid_o
    );
    modport slave (
        output ch0_data_i, ch1_data_i, ch0_valid_i, ch1_valid_i, udma_ready_i,
        input  ch0_ready_o, ch1_ready_o, udma_data_o, udma_chid_o, udma_valid_o
    );
endinterface

// File: rtl/i2s_rx_stream_arbiter.sv
// i2s_rx_stream_arbiter: merges ch0/ch1 sample words into one registered uDMA stream, in strict turn order.
module i2s_rx_stream_arbiter (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_2ch_i,
    input  logic [3:0]             cfg_num_word_i,
    input  logic                   cfg_rx_continuous_i,
    output logic                   evt_done_o,
    output logic                   sts_busy_o,
    output logic [4:0]             sts_count_o,
    i2s_rx_stream_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT_CH0, WAIT_CH1, DONE} state_e;
    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        chid_q, chid_d, valid_q, valid_d, done_q, done_d;
    logic [4:0]  count_q, count_d, count_inc;
    logic        slot_free, rdy0, rdy1, acc0, acc1, acc, last;
    always_comb begin
        slot_free = !valid_q || bus.udma_ready_i;
        rdy0      = cfg_en_i && state_q == WAIT_CH0 && slot_free;
        rdy1      = cfg_en_i && state_q == WAIT_CH1 && slot_free;
        acc0      = rdy0 && bus.ch0_valid_i;
        acc1      = rdy1 && bus.ch1_valid_i;
        acc       = acc0 || acc1;
        count_inc = count_q + 5'd1;
        last      = !cfg_rx_continuous_i && acc && count_inc == {1'b0, cfg_num_word_i} + 5'd1;
        state_d   = !cfg_en_i ? IDLE :
                    state_q == IDLE ? WAIT_CH0 :
                    last ? DONE :
                    acc0 ? (cfg_2ch_i ? WAIT_CH1 : WAIT_CH0) :
                    acc1 ? WAIT_CH0 : state_q;
        // a new accept refills the slot in the same cycle the old word leaves
        valid_d   = cfg_en_i && (acc || (valid_q && !bus.udma_ready_i));
        data_d    = acc0 ? bus.ch0_data_i : acc1 ? bus.ch1_data_i : data_q;
        chid_d    = acc ? acc1 : chid_q;
        count_d   = (!cfg_en_i || state_q == IDLE) ? 5'd0 : acc ? count_inc : count_q;
        done_d    = last;
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            chid_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chid_q  <= chid_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end
    assign bus.ch0_ready_o  = rdy0;
    assign bus.ch1_ready_o  = rdy1;
    assign bus.udma_data_o  = data_q;
    assign bus.udma_chid_o  = chid_q;
    assign bus.udma_valid_o = valid_q;
    assign evt_done_o       = done_q;
    assign sts_count_o      = count_q;
    assign sts_busy_o       = state_q == WAIT_CH0 || state_q == WAIT_CH1 || valid_q;
endmodule

// File: tb/tb_i2s_rx_stream_arbiter.sv
// tb_i2s_rx_stream_arbiter: vector table, directed corner sequences and a randomized scoreboard run.
module tb_i2s_rx_stream_arbiter;
    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       cfg_en_i, cfg_2ch_i, cfg_rx_continuous_i;
    logic [3:0] cfg_num_word_i;
    logic       evt_done_o, sts_busy_o;
    logic [4:0] sts_count_o;
    int         tests = 0;
    int         fails = 0;

    i2s_rx_stream_arbiter_if bus ();

    i2s_rx_stream_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_2ch_i(cfg_2ch_i),
        .cfg_num_word_i(cfg_num_word_i), .cfg_rx_continuous_i(cfg_rx_continuous_i),
        .evt_done_o(evt_done_o), .sts_busy_o(sts_busy_o), .sts_count_o(sts_count_o),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        en, v0, v1, urdy;
        logic [31:0] d0, d1;
        logic        r0, r1, vld;
        logic [31:0] data;
        logic        chid, done;
        logic [4:0]  cnt;
        logic        busy;
    } vec_t;
    vec_t vt[9];

    typedef struct {
        logic        chid;
        logic [31:0] data;
    } word_t;
    word_t       got[$];
    logic [31:0] src0[32], src1[32];
    int          i0, i1, tot, done_seen, k;
    logic        a0, a1, prev_stall, prev_chid;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // expected k-th word of a transfer, straight from the turn-order rule
    function automatic word_t exp_word(input int n);
        word_t w;
        w.chid = cfg_2ch_i ? 1'(n % 2) : 1'b0;
        w.data = cfg_2ch_i ? (w.chid ? src1[n / 2] : src0[n / 2]) : src0[n];
        return w;
    endfunction

    task automatic rnd_cycle(input bit drain);
        smp();
        check("rnd_count", 32'(sts_count_o), 32'(tot));
        if (!cfg_2ch_i) check("rnd_no_ch1_ready", 32'(bus.ch1_ready_o), 32'd0);
        if (prev_stall) begin
            check("rnd_stall_data", bus.udma_data_o, prev_data);
            check("rnd_stall_chid", 32'(bus.udma_chid_o), 32'(prev_chid));
        end
        if (evt_done_o) begin
            done_seen++;
            check("rnd_done_count", 32'(sts_count_o), 32'(cfg_num_word_i) + 32'd1);
        end
        a0 = bus.ch0_valid_i && bus.ch0_ready_o;
        a1 = bus.ch1_valid_i && bus.ch1_ready_o;
        if (bus.udma_valid_o && bus.udma_ready_i) got.push_back('{bus.udma_chid_o, bus.udma_data_o});
        prev_stall = bus.udma_valid_o && !bus.udma_ready_i;
        prev_data  = bus.udma_data_o;
        prev_chid  = bus.udma_chid_o;
        step();
        if (a0) i0++;
        if (a1) i1++;
        tot += int'(a0) + int'(a1);
        bus.ch0_valid_i  = ($urandom % 4) != 0;
        bus.ch1_valid_i  = ($urandom % 4) != 0;
        bus.udma_ready_i = drain ? 1'b1 : 1'($urandom % 2);
        bus.ch0_data_i   = src0[i0];
        bus.ch1_data_i   = src1[i1];
    endtask

    initial begin
        rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_2ch_i = 1'b1; cfg_num_word_i = 4'd3; cfg_rx_continuous_i = 1'b0;
        bus.ch0_valid_i = 1'b1; bus.ch1_valid_i = 1'b1; bus.udma_ready_i = 1'b1;
        bus.ch0_data_i = 32'hA0; bus.ch1_data_i = 32'hB0;
        #12;
        check("rst_valid", 32'(bus.udma_valid_o), 32'd0);
        check("rst_data", bus.udma_data_o, 32'd0);
        check("rst_rdy0", 32'(bus.ch0_ready_o), 32'd0);
        check("rst_rdy1", 32'(bus.ch1_ready_o), 32'd0);
        check("rst_busy", 32'(sts_busy_o), 32'd0);
        check("rst_count", 32'(sts_count_o), 32'd0);
        @(negedge clk_i) rstn_i = 1'b1;
        step();

        // two-channel bounded transfer of 4 words with an always-ready sink
        vt[0] = '{1'b1,1'b1,1'b1,1'b1,32'hA0,32'hB0, 1'b0,1'b0,1'b0,32'h00,1'b0,1'b0,5'd0,1'b0};
        vt[1] = '{1'b1,1'b1,1'b1,1'b1,32'hA0,32'hB0, 1'b1,1'b0,1'b0,32'h00,1'b0,1'b0,5'd0,1'b1};
        vt[2] = '{1'b1,1'b1,1'b1,1'b1,32'hA1,32'hB0, 1'b0,1'b1,1'b1,32'hA0,1'b0,1'b0,5'd1,1'b1};
        vt[3] = '{1'b1,1'b1,1'b1,1'b1,32'hA1,32'hB1, 1'b1,1'b0,1'b1,32'hB0,1'b1,1'b0,5'd2,1'b1};
        vt[4] = '{1'b1,1'b1,1'b1,1'b1,32'hA2,32'hB1, 1'b0,1'b1,1'b1,32'hA1,1'b0,1'b0,5'd3,1'b1};
        vt[5] = '{1'b1,1'b1,1'b1,1'b1,32'hA2,32'hB2, 1'b0,1'b0,1'b1,32'hB1,1'b1,1'b1,5'd4,1'b1};
        vt[6] = '{1'b1,1'b1,1'b1,1'b1,32'hA2,32'hB2, 1'b0,1'b0,1'b0,32'hB1,1'b1,1'b0,5'd4,1'b0};
        vt[7] = '{1'b0,1'b1,1'b1,1'b1,32'hA2,32'hB2, 1'b0,1'b0,1'b0,32'hB1,1'b1,1'b0,5'd4,1'b0};
        vt[8] = '{1'b0,1'b1,1'b1,1'b1,32'hA2,32'hB2, 1'b0,1'b0,1'b0,32'hB1,1'b1,1'b0,5'd0,1'b0};
        for (int i = 0; i < 9; i++) begin
            cfg_en_i = vt[i].en; bus.ch0_valid_i = vt[i].v0; bus.ch1_valid_i = vt[i].v1;
            bus.udma_ready_i = vt[i].urdy; bus.ch0_data_i = vt[i].d0; bus.ch1_data_i = vt[i].d1;
            smp();
            check($sformatf("vec%0d_rdy0", i), 32'(bus.ch0_ready_o), 32'(vt[i].r0));
            check($sformatf("vec%0d_rdy1", i), 32'(bus.ch1_ready_o), 32'(vt[i].r1));
            check($sformatf("vec%0d_valid", i), 32'(bus.udma_valid_o), 32'(vt[i].vld));
            check($sformatf("vec%0d_data", i), bus.udma_data_o, vt[i].data);
            check($sformatf("vec%0d_chid", i), 32'(bus.udma_chid_o), 32'(vt[i].chid));
            check($sformatf("vec%0d_done", i), 32'(evt_done_o), 32'(vt[i].done));
            check($sformatf("vec%0d_count", i), 32'(sts_count_o), 32'(vt[i].cnt));
            check($sformatf("vec%0d_busy", i), 32'(sts_busy_o), 32'(vt[i].busy));
            step();
        end

        // backpressure: word held stable for 5 cycles, then stream resumes in order
        cfg_en_i = 1'b0; step();
        cfg_2ch_i = 1'b1; cfg_rx_continuous_i = 1'b1; bus.udma_ready_i = 1'b1;
        bus.ch0_valid_i = 1'b1; bus.ch1_valid_i = 1'b1; bus.ch0_data_i = 32'h11; bus.ch1_data_i = 32'h22;
        cfg_en_i = 1'b1;
        step(); step();
        bus.udma_ready_i = 1'b0; bus.ch0_data_i = 32'h33;
        for (int c = 0; c < 5; c++) begin
            smp();
            check("bp_data", bus.udma_data_o, 32'h11);
            check("bp_valid", 32'(bus.udma_valid_o), 32'd1);
            check("bp_rdy0", 32'(bus.ch0_ready_o), 32'd0);
            check("bp_rdy1", 32'(bus.ch1_ready_o), 32'd0);
            step();
        end
        bus.udma_ready_i = 1'b1;
        smp(); check("bp_resume_rdy1", 32'(bus.ch1_ready_o), 32'd1); step();
        smp(); check("bp_word1", bus.udma_data_o, 32'h22); check("bp_chid1", 32'(bus.udma_chid_o), 32'd1); step();
        smp(); check("bp_word2", bus.udma_data_o, 32'h33); check("bp_chid2", 32'(bus.udma_chid_o), 32'd0);
        step();

        // ch1 valid early in WAIT_CH0 is held until ch0 has gone
        cfg_en_i = 1'b0; bus.ch0_valid_i = 1'b0; bus.ch1_valid_i = 1'b1;
        bus.ch0_data_i = 32'h44; bus.ch1_data_i = 32'h55; bus.udma_ready_i = 1'b1;
        step();
        cfg_en_i = 1'b1; step();
        for (int c = 0; c < 3; c++) begin
            smp();
            check("ooo_rdy1", 32'(bus.ch1_ready_o), 32'd0);
            check("ooo_valid", 32'(bus.udma_valid_o), 32'd0);
            step();
        end
        bus.ch0_valid_i = 1'b1;
        smp(); check("ooo_rdy0", 32'(bus.ch0_ready_o), 32'd1); step();
        bus.ch0_valid_i = 1'b0;
        smp(); check("ooo_first", bus.udma_data_o, 32'h44); check("ooo_first_chid", 32'(bus.udma_chid_o), 32'd0);
        check("ooo_rdy1_turn", 32'(bus.ch1_ready_o), 32'd1); step();
        smp(); check("ooo_second", bus.udma_data_o, 32'h55); check("ooo_second_chid", 32'(bus.udma_chid_o), 32'd1);

        // enable dropped with a word pending flushes it; restart begins at ch0
        bus.udma_ready_i = 1'b0;
        step();
        cfg_en_i = 1'b0;
        smp(); check("en_pending", 32'(bus.udma_valid_o), 32'd1); check("en_rdy0_forced", 32'(bus.ch0_ready_o), 32'd0);
        step();
        smp(); check("en_flush_valid", 32'(bus.udma_valid_o), 32'd0); check("en_flush_count", 32'(sts_count_o), 32'd0);
        check("en_flush_busy", 32'(sts_busy_o), 32'd0);
        step();
        cfg_en_i = 1'b1; bus.udma_ready_i = 1'b1; bus.ch0_valid_i = 1'b1; bus.ch0_data_i = 32'h66;
        step();
        smp(); check("en_restart_rdy0", 32'(bus.ch0_ready_o), 32'd1); check("en_restart_rdy1", 32'(bus.ch1_ready_o), 32'd0);
        step();
        smp(); check("en_restart_data", bus.udma_data_o, 32'h66); check("en_restart_count", 32'(sts_count_o), 32'd1);

        // asynchronous reset mid-transfer, checked between clock edges
        #1 rstn_i = 1'b0;
        #1;
        check("arst_valid", 32'(bus.udma_valid_o), 32'd0);
        check("arst_data", bus.udma_data_o, 32'd0);
        check("arst_chid", 32'(bus.udma_chid_o), 32'd0);
        check("arst_count", 32'(sts_count_o), 32'd0);
        check("arst_done", 32'(evt_done_o), 32'd0);
        check("arst_busy", 32'(sts_busy_o), 32'd0);
        check("arst_rdy0", 32'(bus.ch0_ready_o), 32'd0);
        check("arst_rdy1", 32'(bus.ch1_ready_o), 32'd0);
        #1 rstn_i = 1'b1;
        step();
        smp(); check("arst_first_rdy0", 32'(bus.ch0_ready_o), 32'd1); check("arst_no_word", 32'(bus.udma_valid_o), 32'd0);
        step();
        smp(); check("arst_first_word", bus.udma_data_o, 32'h66); check("arst_first_valid", 32'(bus.udma_valid_o), 32'd1);
        step();

        // single-channel continuous stream: 1 word/cycle, count wraps, no done
        cfg_en_i = 1'b0; step();
        cfg_2ch_i = 1'b0; cfg_rx_continuous_i = 1'b1; bus.ch0_valid_i = 1'b1; bus.ch1_valid_i = 1'b1;
        bus.udma_ready_i = 1'b1; k = 0; bus.ch0_data_i = 32'hC000; cfg_en_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            smp();
            check("cont_rdy1", 32'(bus.ch1_ready_o), 32'd0);
            check("cont_done", 32'(evt_done_o), 32'd0);
            check("cont_count", 32'(sts_count_o), 32'(k % 32));
            if (c > 0) check("cont_rdy0", 32'(bus.ch0_ready_o), 32'd1);
            if (k > 0) check("cont_data", bus.udma_data_o, 32'hC000 + 32'(k - 1));
            a0 = bus.ch0_valid_i && bus.ch0_ready_o;
            step();
            if (a0) k++;
            bus.ch0_data_i = 32'hC000 + 32'(k);
        end

        // randomized bounded transfers against a turn-order scoreboard
        cfg_rx_continuous_i = 1'b0;
        for (int it = 0; it < 12; it++) begin
            int n;
            cfg_en_i = 1'b0; bus.ch0_valid_i = 1'b0; bus.ch1_valid_i = 1'b0; bus.udma_ready_i = 1'b1;
            cfg_2ch_i = 1'($urandom % 2); cfg_num_word_i = 4'($urandom_range(0, 15));
            step();
            for (int j = 0; j < 32; j++) begin src0[j] = $urandom; src1[j] = $urandom; end
            i0 = 0; i1 = 0; tot = 0; done_seen = 0; prev_stall = 1'b0; got.delete();
            bus.ch0_data_i = src0[0]; bus.ch1_data_i = src1[0];
            cfg_en_i = 1'b1;
            n = 0;
            while (!(done_seen > 0 && !bus.udma_valid_o) && n < 400) begin
                rnd_cycle(1'b0);
                n++;
            end
            check("rnd_timeout", 32'(n < 400), 32'd1);
            repeat (4) rnd_cycle(1'b1);
            check("rnd_words", 32'(got.size()), 32'(cfg_num_word_i) + 32'd1);
            check("rnd_accepts", 32'(tot), 32'(cfg_num_word_i) + 32'd1);
            check("rnd_done_once", 32'(done_seen), 32'd1);
            for (int j = 0; j <= int'(cfg_num_word_i) && j < got.size(); j++) begin
                word_t w;
                w = exp_word(j);
                check($sformatf("rnd%0d_w%0d_data", it, j), got[j].data, w.data);
                check($sformatf("rnd%0d_w%0d_chid", it, j), 32'(got[j].chid), 32'(w.chid));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
